// File: rtl/ahb5_slave_mem.sv
// ----------------------------------------------------------------------------
// ahb5_slave_mem
//
// AHB5 subordinate backed by a word-organised on-chip memory. Each accepted
// transfer gets either an OKAY response after WAIT_CYCLES wait states or a
// two-cycle ERROR response. Byte and half-word writes update only their lanes,
// in little-endian order. Back-to-back pipelined transfers are supported.
//
// Parameters
//   MEM_DEPTH   number of 32-bit words in the memory
//   WAIT_CYCLES wait states inserted before each OKAY completion (0..15)
//
// Ports
//   Hclk       clock, all state on the rising edge
//   HReset     synchronous active-high reset
//   HSEL       subordinate select
//   HADDR      byte address (address phase)
//   HTRANS     IDLE / BUSY / NONSEQ / SEQ
//   HWRITE     1 = write, 0 = read
//   HSIZE      0 = byte, 1 = half-word, 2 = word
//   HBURST     not used; every beat carries its own address
//   HWDATA     write data (data phase)
//   HREADY     bus ready; an address phase is taken only when it is high
//   HRDATA     read data; zero outside a read completion cycle
//   HREADYOUT  subordinate ready
//   HRESP      0 = OKAY, 1 = ERROR
// ----------------------------------------------------------------------------
module ahb5_slave_mem #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        Hclk,
  input  logic        HReset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DONE,
    ERR1,
    ERR2
  } state_t;

  state_t            state;
  logic [3:0]        wcnt;
  logic [31:0]       addr_p1;
  logic              write_p1;
  logic [2:0]        size_p1;
  logic              hreadyout_r;
  logic              hresp_r;

  logic              addr_window;
  logic              accept;
  logic              legal;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        lanes;
  logic              unused_bits;

  logic [31:0]       mem [MEM_DEPTH];

  // A transfer is illegal when it falls outside the memory or is misaligned
  // or oversized for its HSIZE.
  function automatic logic is_legal(input logic [31:0] a, input logic [2:0] sz);
    logic ok;
    ok = ({2'b00, a[31:2]} < 32'(MEM_DEPTH));
    if (sz > 3'd2) ok = 1'b0;
    if ((sz == 3'd1) && a[0]) ok = 1'b0;
    if ((sz == 3'd2) && (a[1:0] != 2'b00)) ok = 1'b0;
    return ok;
  endfunction

  // Little-endian byte-lane enables for a legal transfer.
  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] sz);
    logic [3:0] m;
    case (sz)
      3'd0:    m = 4'b0001 << a;
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Address phases are only taken in states whose data phase is ending with
  // HREADYOUT=1 (or no data phase at all).
  assign addr_window = (state == IDLE) || (state == DONE) || (state == ERR2);
  assign accept      = addr_window && HSEL && HREADY && HTRANS[1];
  assign legal       = is_legal(HADDR, HSIZE);

  // ---- address phase -> data phase (p1) ----
  always_ff @(posedge Hclk) begin
    if (HReset) begin
      state       <= IDLE;
      wcnt        <= 4'd0;
      addr_p1     <= 32'd0;
      write_p1    <= 1'b0;
      size_p1     <= 3'd0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR2: begin
          if (accept) begin
            addr_p1  <= HADDR;
            write_p1 <= HWRITE;
            size_p1  <= HSIZE;
            if (!legal) begin
              state       <= ERR1;
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b1;
            end else if (WAIT_CYCLES > 0) begin
              state       <= WAIT;
              wcnt        <= WAIT_LOAD;
              hreadyout_r <= 1'b0;
              hresp_r     <= 1'b0;
            end else begin
              state       <= DONE;
              hreadyout_r <= 1'b1;
              hresp_r     <= 1'b0;
            end
          end else begin
            state       <= IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
          end
        end
        WAIT: begin
          // Counter starts at WAIT_CYCLES, so leaving at 1 gives exactly
          // WAIT_CYCLES low-ready cycles.
          if (wcnt <= 4'd1) begin
            state       <= DONE;
            wcnt        <= 4'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        ERR1: begin
          state       <= ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          wcnt        <= 4'd0;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b0;
        end
      endcase
    end
  end

  assign idx   = addr_p1[IDX_W+1:2];
  assign lanes = lane_mask(addr_p1[1:0], size_p1);

  // ---- data phase completion: memory write ----
  // Only a legal transfer reaches DONE, so idx is always in range here.
  always_ff @(posedge Hclk) begin
    if (!HReset && (state == DONE) && write_p1) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Reset forces the idle response combinationally so it also holds during
  // the reset cycle itself, not only after it.
  assign HREADYOUT = hreadyout_r | HReset;
  assign HRESP     = hresp_r & ~HReset;
  assign HRDATA    = (!HReset && (state == DONE) && !write_p1) ? mem[idx] : 32'd0;

  assign unused_bits = ^{HBURST, HTRANS[0], addr_p1};

endmodule

// File: tb/tb_ahb5_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_ahb5_slave_mem
//
// Three subordinates (0, 3 and 5 wait states) share one pipelined master.
// Only the instance selected by 'cur' sees HSEL; each instance's HREADY is
// its own HREADYOUT. Stimulus pushes the expected completion of every
// accepted transfer into a queue; a monitor follows the data phases of the
// selected instance and checks each completion plus every idle cycle.
// ----------------------------------------------------------------------------
module tb_ahb5_slave_mem;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  typedef struct {
    string       nm;
    int          waits;
    bit          resp;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel_drv;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] held_wdata;
  int          cur;

  logic        hreadyout [3];
  logic        hresp     [3];
  logic [31:0] hrdata    [3];

  exp_t sb[$];
  int   vectors = 0;
  int   fails   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb5_slave_mem #(
      .MEM_DEPTH  (256),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 5))
    ) u_dut (
      .Hclk     (clk),
      .HReset   (rst),
      .HSEL     (hsel_drv && (cur == g)),
      .HADDR    (haddr),
      .HTRANS   (htrans),
      .HWRITE   (hwrite),
      .HSIZE    (hsize),
      .HBURST   (hburst),
      .HWDATA   (hwdata),
      .HREADY   (hreadyout[g]),
      .HRDATA   (hrdata[g]),
      .HREADYOUT(hreadyout[g]),
      .HRESP    (hresp[g])
    );
  end

  // One address phase; HWDATA carries the data of the phase now completing.
  task automatic beat(input bit sel, input logic [1:0] tr, input logic [31:0] a,
                      input bit wr, input logic [2:0] sz, input logic [31:0] wd);
    int n;
    hsel_drv = sel;
    htrans   = tr;
    haddr    = a;
    hwrite   = wr;
    hsize    = sz;
    hwdata   = held_wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((hreadyout[cur] !== 1'b1) && (n < 64));
    if (hreadyout[cur] !== 1'b1) begin
      vectors++;
      fails++;
      $display("FAIL beat_timeout addr=%h: HREADYOUT still %b after %0d cycles, required 1",
               a, hreadyout[cur], n);
    end
    held_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input string nm, input logic [31:0] a, input bit wr,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input int ew, input bit er, input logic [31:0] ed);
    exp_t e;
    e.nm = nm; e.waits = ew; e.resp = er; e.rdata = ed;
    sb.push_back(e);
    beat(1'b1, T_NONSEQ, a, wr, sz, wd);
  endtask

  task automatic flush();
    beat(1'b0, T_IDLE, 32'd0, 1'b0, 3'd0, 32'd0);
  endtask

  // Monitor state
  bit          dp_active = 0;
  int          waits;
  bit          low_resp;
  bit          mixed;
  logic        ro, rs;
  logic [31:0] rd;
  exp_t        e_pop;
  bit          exp_low;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      ro = hreadyout[cur];
      rs = hresp[cur];
      rd = hrdata[cur];
      if (rst || !dp_active) begin
        dp_active = 0;
        vectors++;
        if ((ro !== 1'b1) || (rs !== 1'b0) || (rd !== 32'd0)) begin
          fails++;
          $display("FAIL idle_cycle cur=%0d rst=%b: got ready=%b resp=%b rdata=%h, required ready=1 resp=0 rdata=00000000",
                   cur, rst, ro, rs, rd);
        end
      end else if (ro !== 1'b1) begin
        if (waits == 0) low_resp = rs;
        else if (rs !== low_resp) mixed = 1;
        waits++;
      end else begin
        dp_active = 0;
        vectors++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_completion cur=%0d: resp=%b rdata=%h with no transfer expected",
                   cur, rs, rd);
        end else begin
          e_pop   = sb.pop_front();
          exp_low = (e_pop.waits > 0) ? e_pop.resp : 1'b0;
          if ((waits != e_pop.waits) || (low_resp !== exp_low) || mixed ||
              (rs !== e_pop.resp) || (rd !== e_pop.rdata)) begin
            fails++;
            $display("FAIL %s: got waits=%0d low_resp=%b mixed=%b resp=%b rdata=%h, required waits=%0d low_resp=%b mixed=0 resp=%b rdata=%h",
                     e_pop.nm, waits, low_resp, mixed, rs, rd,
                     e_pop.waits, exp_low, e_pop.resp, e_pop.rdata);
          end
        end
      end
      if (!rst && hsel_drv && htrans[1] && (ro === 1'b1)) begin
        dp_active = 1;
        waits     = 0;
        low_resp  = 0;
        mixed     = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    hsel_drv   = 1'b0;
    haddr      = 32'd0;
    htrans     = T_IDLE;
    hwrite     = 1'b0;
    hsize      = 3'd0;
    hburst     = 3'b001;
    hwdata     = 32'd0;
    held_wdata = 32'd0;
    cur        = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero wait states: write then read back-to-back, lanes, errors, idle/busy.
    xfer("wr10",        32'h10,  1, 3'd2, 32'hDEADBEEF, 0, 0, 32'h0);
    xfer("rd10",        32'h10,  0, 3'd2, 32'hFFFFFFFF, 0, 0, 32'hDEADBEEF);
    xfer("wr0",         32'h0,   1, 3'd2, 32'h00000000, 0, 0, 32'h0);
    xfer("wrb2",        32'h2,   1, 3'd0, 32'h11AA2233, 0, 0, 32'h0);
    xfer("wrh0",        32'h0,   1, 3'd1, 32'h55661234, 0, 0, 32'h0);
    xfer("rd0",         32'h0,   0, 3'd2, 32'hFFFFFFFF, 0, 0, 32'h00AA1234);
    xfer("rdb2",        32'h2,   0, 3'd0, 32'hFFFFFFFF, 0, 0, 32'h00AA1234);
    xfer("err_rd400",   32'h400, 0, 3'd2, 32'hFFFFFFFF, 1, 1, 32'h0);
    xfer("err_wr3",     32'h3,   1, 3'd2, 32'hFFFFFFFF, 1, 1, 32'h0);
    xfer("err_h1",      32'h1,   1, 3'd1, 32'hFFFFFFFF, 1, 1, 32'h0);
    xfer("err_sz3",     32'h0,   1, 3'd3, 32'hFFFFFFFF, 1, 1, 32'h0);
    xfer("rd0_posterr", 32'h0,   0, 3'd2, 32'h0,        0, 0, 32'h00AA1234);
    beat(1'b1, T_BUSY,   32'h0,  1'b1, 3'd2, 32'hBAD0BAD0);
    beat(1'b1, T_IDLE,   32'h0,  1'b1, 3'd2, 32'hBAD0BAD0);
    beat(1'b0, T_NONSEQ, 32'h0,  1'b1, 3'd2, 32'hBAD0BAD0);
    beat(1'b0, T_NONSEQ, 32'h10, 1'b1, 3'd2, 32'hBAD0BAD0);
    xfer("rd0_postidle",  32'h0,   0, 3'd2, 32'h0,        0, 0, 32'h00AA1234);
    xfer("rd10_postidle", 32'h10,  0, 3'd2, 32'h0,        0, 0, 32'hDEADBEEF);
    xfer("wr3fc",         32'h3FC, 1, 3'd2, 32'h0F0F0F0F, 0, 0, 32'h0);
    xfer("rd3fc",         32'h3FC, 0, 3'd2, 32'h0,        0, 0, 32'h0F0F0F0F);
    flush();

    // Three wait states.
    cur = 1;
    xfer("w3_wr10",  32'h10,  1, 3'd2, 32'h01234567, 3, 0, 32'h0);
    xfer("w3_rd10",  32'h10,  0, 3'd2, 32'hFFFFFFFF, 3, 0, 32'h01234567);
    xfer("w3_err",   32'h400, 0, 3'd2, 32'h0,        1, 1, 32'h0);
    xfer("w3_rd10b", 32'h10,  0, 3'd2, 32'h0,        3, 0, 32'h01234567);
    flush();

    // Five wait states, reset in the second wait cycle of a write.
    cur = 2;
    xfer("w5_wr20", 32'h20, 1, 3'd2, 32'h11111111, 5, 0, 32'h0);
    xfer("w5_rd20", 32'h20, 0, 3'd2, 32'h0,        5, 0, 32'h11111111);
    beat(1'b1, T_NONSEQ, 32'h20, 1'b1, 3'd2, 32'h00000055);
    hsel_drv = 1'b0;
    htrans   = T_IDLE;
    hwdata   = held_wdata;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    held_wdata = 32'd0;
    hwdata     = 32'd0;
    xfer("w5_rd20_postrst", 32'h20, 0, 3'd2, 32'h0, 5, 0, 32'h11111111);
    flush();

    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected completions never seen, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
